// File: rtl/pitch_pkg.sv
// Shared definitions for the pitch stabiliser.
// Holds the FSM state type and the default parameter values used by the
// top level and by the sample window.
package pitch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StTrack,
        StLocked
    } pitch_state_e;

    localparam int unsigned DefW     = 10;
    localparam int unsigned DefNavg  = 4;
    localparam int unsigned DefTol   = 2;
    localparam int unsigned DefLockN = 3;

endpackage

// File: rtl/sample_window.sv
// Sliding window over the last NAVG accepted pitch samples.
// Keeps a running sum updated incrementally and exposes both the current
// average and the average the window would have if 'sample' were pushed now.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           synchronous clear of window and sum
//   push            accept 'sample' this cycle
//   sample [W-1:0]  sample to push
//   avg            average before any push (sum >> log2(NAVG))
//   avg_next       average after pushing 'sample'
module sample_window
    import pitch_pkg::*;
#(
    parameter int unsigned W    = DefW,
    parameter int unsigned NAVG = DefNavg  // power of two, 2..16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] sample,
    output logic [W-1:0] avg,
    output logic [W-1:0] avg_next
);

    localparam int unsigned LogN = $clog2(NAVG);
    localparam int unsigned SW   = W + LogN;

    logic [W-1:0]  win_q [NAVG];
    logic [SW-1:0] sum_q;
    logic [SW-1:0] sum_d;

    // The oldest sample is always part of the sum, so the modular result
    // never goes negative in real terms.
    assign sum_d    = sum_q + SW'(sample) - SW'(win_q[NAVG-1]);
    assign avg      = sum_q[SW-1:LogN];
    assign avg_next = sum_d[SW-1:LogN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NAVG; i++) win_q[i] <= '0;
            sum_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < NAVG; i++) win_q[i] <= '0;
            sum_q <= '0;
        end else if (push) begin
            win_q[0] <= sample;
            for (int i = 1; i < NAVG; i++) win_q[i] <= win_q[i-1];
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/pitch_stabiliser.sv
// Pitch stabiliser: smooths FFT bin estimates from a pitch detector and
// only reports a pitch once it has been stable for LOCK_N estimates.
// Ports:
//   clk              audio-codec clock, all logic on posedge
//   reset            asynchronous active-low reset
//   in_data [W-1:0]  bin index from pitch detector
//   in_valid         one-cycle qualifier for in_data, always consumed
//   out_data [W-1:0] stabilised bin index, held between updates
//   out_valid        one-cycle pulse when out_data is loaded
//   locked           high while in the locked state
module pitch_stabiliser
    import pitch_pkg::*;
#(
    parameter int unsigned W       = DefW,
    parameter int unsigned NAVG    = DefNavg,
    parameter int unsigned TOL     = DefTol,
    parameter int unsigned LOCK_N  = DefLockN,
    parameter int unsigned TIMEOUT = 18432000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         locked
);

    localparam int unsigned FW = $clog2(NAVG + 1);
    localparam int unsigned CW = $clog2(LOCK_N + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [FW-1:0] FillLast = FW'(NAVG - 1);
    localparam logic [CW-1:0] LockLast = CW'(LOCK_N - 1);
    localparam logic [TW-1:0] TMax     = TW'(TIMEOUT);
    localparam logic [TW-1:0] TPre     = TW'(TIMEOUT - 1);
    localparam logic [W:0]    TolV     = (W+1)'(TOL);
    localparam logic [W:0]    HalfTolV = (W+1)'(TOL / 2);

    pitch_state_e  state_q;
    logic [FW-1:0] fill_cnt_q;
    logic [CW-1:0] match_cnt_q;
    logic [CW-1:0] miss_cnt_q;
    logic [TW-1:0] silence_q;

    logic [W-1:0]  avg;
    logic [W-1:0]  avg_next;
    logic signed [W:0] diff;
    logic signed [W:0] drift;
    logic [W:0]    abs_diff;
    logic [W:0]    abs_drift;
    logic          match;
    logic          big_drift;
    logic          timeout;
    logic          win_push;

    // One extra bit so differences near bin 0 or the top bin cannot wrap.
    always_comb begin
        diff      = $signed({1'b0, in_data}) - $signed({1'b0, avg});
        drift     = $signed({1'b0, avg_next}) - $signed({1'b0, out_data});
        abs_diff  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        abs_drift = drift[W] ? $unsigned(-drift) : $unsigned(drift);
        match     = abs_diff <= TolV;
        big_drift = abs_drift > HalfTolV;
        // A valid input always wins over an expiring silence counter.
        timeout   = !in_valid && (silence_q == TPre) && (state_q != StIdle);
        // Outliers seen while locked are not allowed to pollute the window.
        win_push  = in_valid && !timeout && ((state_q != StLocked) || match);
    end

    sample_window #(
        .W    (W),
        .NAVG (NAVG)
    ) u_window (
        .clk      (clk),
        .reset    (reset),
        .clear    (timeout),
        .push     (win_push),
        .sample   (in_data),
        .avg      (avg),
        .avg_next (avg_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            silence_q   <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                silence_q <= '0;
            end else if (silence_q != TMax) begin
                silence_q <= silence_q + TW'(1);
            end

            if (timeout) begin
                state_q     <= StIdle;
                fill_cnt_q  <= '0;
                match_cnt_q <= '0;
                miss_cnt_q  <= '0;
                locked      <= 1'b0;
                if (out_data != '0) begin
                    out_data  <= '0;
                    out_valid <= 1'b1;
                end
            end else if (in_valid) begin
                unique case (state_q)
                    StIdle: begin
                        fill_cnt_q <= FW'(1);
                        state_q    <= StFill;
                    end
                    StFill: begin
                        fill_cnt_q <= fill_cnt_q + FW'(1);
                        if (fill_cnt_q == FillLast) begin
                            state_q     <= StTrack;
                            match_cnt_q <= '0;
                        end
                    end
                    StTrack: begin
                        if (!match) begin
                            match_cnt_q <= '0;
                        end else if (match_cnt_q == LockLast) begin
                            state_q     <= StLocked;
                            locked      <= 1'b1;
                            match_cnt_q <= '0;
                            miss_cnt_q  <= '0;
                            out_data    <= avg_next;
                            out_valid   <= 1'b1;
                        end else begin
                            match_cnt_q <= match_cnt_q + CW'(1);
                        end
                    end
                    StLocked: begin
                        if (match) begin
                            miss_cnt_q <= '0;
                            if (big_drift) begin
                                out_data  <= avg_next;
                                out_valid <= 1'b1;
                            end
                        end else if (miss_cnt_q == LockLast) begin
                            state_q     <= StTrack;
                            locked      <= 1'b0;
                            match_cnt_q <= '0;
                            miss_cnt_q  <= '0;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/pitch_stabiliser.md
PITCH_STABILISER -- requirements
Module: pitch_stabiliser

Interface
REQ-001 Parameter W, default 10: width of FFT bin index (log2 of NSamples 1024).
REQ-002 Parameter NAVG, default 4: averaging window depth; SHALL be a power of two, 2..16.
REQ-003 Parameter TOL, default 2: bin tolerance for "same pitch".
REQ-004 Parameter LOCK_N, default 3: consecutive in-tolerance (or out-of-tolerance) estimates needed to lock (or unlock).
REQ-005 Parameter TIMEOUT, default 18432000: clk cycles without input before silence is declared (1 s at 18.432 MHz).
REQ-006 clk  input  1  single clock, the 18.432 MHz audio-codec clock; all logic on posedge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_data  input  W  bin index from pitch detector.
REQ-009 in_valid  input  1  single-cycle qualifier for in_data; no backpressure, every pulse SHALL be consumed.
REQ-010 out_data  output  W  stabilised bin index, held between updates.
REQ-011 out_valid  output  1  one-cycle pulse when out_data changes.
REQ-012 locked  output  1  high while state is LOCKED.

Function
REQ-013 FSM states SHALL be IDLE, FILL, TRACK, LOCKED.
REQ-014 Window: shift register of last NAVG accepted samples plus running sum of W+log2(NAVG) bits; avg = sum >> log2(NAVG), truncating.
REQ-015 Sum update SHALL be sum + new - oldest, never full recomputation.
REQ-016 diff = |in_data - avg|, avg taken before the push; "match" means diff <= TOL.
REQ-017 IDLE: on in_valid push sample, fill_cnt=1, go FILL.
REQ-018 FILL: on in_valid push, fill_cnt++; when fill_cnt reaches NAVG go TRACK with match_cnt=0.
REQ-019 TRACK: on in_valid push; match -> match_cnt++, else match_cnt=0; when match_cnt reaches LOCK_N go LOCKED, load out_data with new avg, pulse out_valid.
REQ-020 LOCKED: on in_valid with match, push, miss_cnt=0; if new avg differs from out_data by more than TOL/2 (integer), load out_data and pulse out_valid.
REQ-021 LOCKED: on in_valid without match, do not push, miss_cnt++; at LOCK_N go TRACK, match_cnt=0, out_data held.
REQ-022 Silence counter SHALL clear on every in_valid and otherwise increment, saturating at TIMEOUT.
REQ-023 Silence counter reaching TIMEOUT in any state except IDLE: go IDLE, clear window, sum and counters; if out_data != 0 load 0 and pulse out_valid.
REQ-024 Simultaneous in_valid and timeout: in_valid wins, counter clears, no timeout action.
REQ-025 Latency: out_data/out_valid/locked SHALL update on the clk edge after the in_valid cycle (1 cycle registered).
REQ-026 Back-to-back in_valid on consecutive cycles SHALL each be processed; no sample dropped.
REQ-027 Differences SHALL be computed in W+1 bits signed; no wrap at bin 0 or bin 2^W-1.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, window, sum, all counters, out_data=0, out_valid=0, locked=0.
REQ-029 Reset mid-operation SHALL discard the window; first valid after release begins FILL anew.

Structure
REQ-030 Shared package pitch_pkg SHALL hold the state enum type and default W/NAVG/TOL/LOCK_N constants.
REQ-031 One sub-module, sample_window (shift register + running sum + avg), SHALL be instantiated once.

Verification
REQ-032 Reset, then 7 valids of 100 spaced 50 cycles -> locked rises after 7th, out_data=100, exactly one out_valid.
REQ-033 Locked at 100, feed 101,99,102 -> no out_valid, out_data stays 100, locked stays 1.
REQ-034 Locked at 100, feed 300 x3 -> locked falls after 3rd, out_data stays 100; then 300 x7 -> relock, out_data=300.
REQ-035 Locked, TIMEOUT=1000, no valid for 1000 cycles -> out_data=0, one out_valid, locked=0; valid on cycle 1000 instead -> no timeout.
REQ-036 Bins 0 and 1023 alternating -> never locks, no wrap-induced match.
REQ-037 Assert reset during FILL after 2 samples -> all outputs 0; 4 fresh samples needed to reach TRACK.
